core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Instruction sequencer for the GPU core array. It holds a small program memory of 16-bit core opcodes.
- On start it fetches the program and broadcasts each core instruction to all cores as opcode plus a one-cycle execute strobe.
- It interprets its own flow-control instructions (HALT, SETLOOP, DJNZ) locally.
- It sits between the host/config interface and the shared opcode/execute bus of all core instances.

Parameters:
- PROG_DEPTH, 32, number of 16-bit words in program memory.
- ADDR_W, 5, program address width, equal to clog2(PROG_DEPTH).
- LOOP_W, 8, loop counter width; must be ≤ ADDR_W+6 so the immediate fits in opcode[10:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_we  in  1  program memory write enable.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  16  program write data.
- start  in  1  begin program run at address 0.
- abort  in  1  terminate run immediately, no done.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse on normal run completion.
- opcode  out  16  instruction broadcast to cores.
- execute  out  1  one-cycle strobe qualifying opcode.
- pc  out  ADDR_W  current program counter (debug).

Behaviour:
- Reset values (asynchronous):
  - state IDLE; pc=0; loop_cnt=0; opcode=0; execute=0; busy=0; done=0.
  - Program memory is not reset.
- Program memory:
  - Synchronous write when prog_we=1 and state=IDLE and start=0.
  - Writes in any other state, or in the same cycle as an accepted start, are ignored.
  - Read is registered, 1-cycle latency.
- Instruction decode, on the fetched word w:
  - w[15:13]=3'b101 is a sequencer op. It is never forwarded and never raises execute.
    - w[12:11]=00 HALT: end the run.
    - w[12:11]=01 SETLOOP: loop_cnt <= w[LOOP_W-1:0]; pc+1.
    - w[12:11]=10 DJNZ: if loop_cnt≠0 then loop_cnt-1 and pc <= w[ADDR_W-1:0]; else pc+1.
    - w[12:11]=11 reserved: NOP, pc+1.
  - Any other w is a core instruction: forward it, pc+1.
- FSM states IDLE, FETCH, EXEC.
  - IDLE: busy=0. start=1 and abort=0 → pc<=0, busy<=1, go to FETCH.
  - FETCH: memory read address = pc → EXEC.
  - EXEC: decode w.
    - Core instruction: opcode<=w, execute<=1.
    - Sequencer ops: execute<=0; opcode holds its previous value.
    - Next state is FETCH with updated pc.
    - Exception, go to IDLE and pulse done next cycle when either:
      - w is HALT, or
      - pc=PROG_DEPTH-1 and w is not a taken DJNZ (end-of-memory termination; the last word still issues if it is a core instruction).
- Registered outputs: execute is high for exactly one cycle after each EXEC of a core instruction and low otherwise.
- Throughput is 1 instruction per 2 cycles.
- Latency: start sampled at edge k → FETCH in cycle k+1, EXEC in k+2, first execute high in cycle k+3, second in k+5.
- Done timing:
  - done and busy=0 appear in the cycle after the terminating EXEC.
  - For end-of-memory termination, done coincides with the execute of the last instruction.
- start while busy is ignored.
- abort=1 in any state:
  - next edge forces IDLE, busy=0, execute=0, done=0;
  - pc and loop_cnt are unchanged until the next start.
  - abort has priority over start and over termination.
- pc wrap: DJNZ target any address 0..PROG_DEPTH-1; no other wrap (end-of-memory terminates).
- loop_cnt persists across runs and is cleared only by reset or SETLOOP.
- opcode holds its last forwarded value while idle.

Test Plan:
- Load {0x0105, 0x4403, 0xA000} and pulse start:
  - execute pulses at start+3 (opcode 0x0105) and at start+5 (0x4403);
  - no execute for HALT; done pulses at start+7; busy is high for 6 cycles.
- Load {0xA805 SETLOOP 5... use 0xA803, 0x4000, 0xB001, 0xA000}:
  - 0x4000 executes 4 times; loop_cnt ends at 0; done asserts.
- Program with no HALT filling all 32 words of 0x4001:
  - 32 execute pulses; done asserts in the same cycle as the 32nd execute.
- Issue prog_we to address 0 with 0xFFFF while busy:
  - the next run shows the original word 0 unchanged.
- Assert abort 2 cycles after the first execute:
  - execute=0, busy=0 on the next cycle; done never asserts.
  - A new start reruns from pc=0.
- Assert rst asynchronously mid-run (not edge-aligned):
  - all outputs go to reset values immediately; program memory is retained, so a subsequent start replays the program correctly.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Host/config and core-broadcast bus of the instruction sequencer.
// The master side is the host (program loader, run control) and observer of
// the broadcast opcode/execute pair; the slave side is the sequencer itself.
interface core_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [15:0]       opcode;
  logic              execute;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, abort,
    input  busy, done, opcode, execute, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, abort,
    output busy, done, opcode, execute, pc
  );
endinterface

// File: rtl/core_sequencer.sv
// Instruction sequencer for the GPU core array.
// Fetches 16-bit words from a small program memory, broadcasts core
// instructions with a one-cycle execute strobe and interprets the local
// flow-control ops (HALT, SETLOOP, DJNZ). One instruction per two cycles.
module core_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5,
  parameter int LOOP_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [2:0]        SEQ_TAG  = 3'b101;
  localparam logic [1:0]        OP_HALT  = 2'b00;
  localparam logic [1:0]        OP_SETLP = 2'b01;
  localparam logic [1:0]        OP_DJNZ  = 2'b10;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [LOOP_W-1:0] loop_cnt_q;
  logic [15:0]       opcode_q;
  logic              execute_q;
  logic              busy_q;
  logic              done_q;

  // Program storage and its registered read port (not reset).
  logic [15:0]       mem_q [PROG_DEPTH];
  logic [15:0]       rd_q;

  logic              prog_wr_en_s;
  logic              is_seq_s;
  logic              is_halt_s;
  logic              is_setloop_s;
  logic              is_djnz_s;
  logic              djnz_taken_s;
  logic              terminate_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [LOOP_W-1:0] loop_next_s;

  // Host writes are only honoured while idle and not racing a start.
  assign prog_wr_en_s = bus.prog_we && (state_q == ST_IDLE) && !bus.start;

  // Program memory write port and one-cycle-latency read at the current pc.
  always_ff @(posedge clk) begin
    if (prog_wr_en_s) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
    rd_q <= mem_q[pc_q];
  end

  // Decode of the fetched word: sequencer-op class, next pc and loop count.
  always_comb begin
    is_seq_s     = 1'b0;
    is_halt_s    = 1'b0;
    is_setloop_s = 1'b0;
    is_djnz_s    = 1'b0;
    djnz_taken_s = 1'b0;
    pc_next_s    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    loop_next_s  = loop_cnt_q;

    if (rd_q[15:13] == SEQ_TAG) begin
      is_seq_s = 1'b1;
      case (rd_q[12:11])
        OP_HALT:  is_halt_s    = 1'b1;
        OP_SETLP: is_setloop_s = 1'b1;
        OP_DJNZ:  is_djnz_s    = 1'b1;
        default:  is_seq_s     = 1'b1;  // reserved encoding behaves as NOP
      endcase
    end else begin
      is_seq_s = 1'b0;
    end

    if (is_setloop_s) begin
      loop_next_s = rd_q[LOOP_W-1:0];
    end else if (is_djnz_s && (loop_cnt_q != {LOOP_W{1'b0}})) begin
      djnz_taken_s = 1'b1;
      loop_next_s  = loop_cnt_q - {{(LOOP_W-1){1'b0}}, 1'b1};
      pc_next_s    = rd_q[ADDR_W-1:0];
    end else begin
      loop_next_s  = loop_cnt_q;
    end

    // A run ends on HALT or when the last word is consumed without a jump.
    terminate_s = is_halt_s || ((pc_q == LAST_PC) && !djnz_taken_s);
  end

  // Run-control FSM with registered broadcast and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= {ADDR_W{1'b0}};
      loop_cnt_q <= {LOOP_W{1'b0}};
      opcode_q   <= 16'h0000;
      execute_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.abort) begin
      // Abort wins over start and termination; pc and loop_cnt are kept.
      state_q   <= ST_IDLE;
      execute_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          execute_q <= 1'b0;
          done_q    <= 1'b0;
          if (bus.start) begin
            pc_q    <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          execute_q <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!is_seq_s) begin
            opcode_q  <= rd_q;
            execute_q <= 1'b1;
          end else begin
            execute_q <= 1'b0;
          end
          loop_cnt_q <= loop_next_s;
          if (terminate_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q    <= pc_next_s;
            state_q <= ST_FETCH;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          execute_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.opcode  = opcode_q;
  assign bus.execute = execute_q;
  assign bus.pc      = pc_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: an instruction-level reference model
// predicts the busy/done/execute/opcode trace of each run cycle by cycle.
module tb_core_sequencer;

  localparam int PROG_DEPTH = 32;
  localparam int ADDR_W     = 5;
  localparam int LOOP_W     = 8;
  localparam int MAXT       = 300;
  localparam int TLEN       = MAXT + 4;

  logic clk;
  logic rst;

  core_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  core_sequencer #(
    .PROG_DEPTH(PROG_DEPTH),
    .ADDR_W    (ADDR_W),
    .LOOP_W    (LOOP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [15:0] mdl_mem [PROG_DEPTH];
  int          mdl_cnt;
  logic [15:0] mdl_op;

  // Expected per-cycle trace, index t = edges after the start-sampling edge
  bit          e_busy [TLEN];
  bit          e_done [TLEN];
  bit          e_exec [TLEN];
  logic [15:0] e_word [TLEN];
  logic [15:0] e_op   [TLEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level model: instruction n executes at t=2+2n; a run ends on
  // HALT or the last word without a taken jump, or is cut off by abort.
  task automatic build_trace(input int abort_at, output int term_t, output int end_t);
    int pc, n, te, nxt, stop_t;
    logic [15:0] w, cur;
    bit taken, halt;
    for (int t = 0; t < TLEN; t++) begin
      e_busy[t] = 1'b1; e_done[t] = 1'b0; e_exec[t] = 1'b0; e_word[t] = 16'h0;
    end
    pc = 0; n = 0; term_t = -1;
    while (term_t < 0 && (2 + 2*n) < abort_at) begin
      w = mdl_mem[pc]; te = 2 + 2*n; taken = 1'b0; halt = 1'b0; nxt = pc + 1;
      if (w[15:13] == 3'b101) begin
        case (w[12:11])
          2'b00: halt = 1'b1;
          2'b01: mdl_cnt = int'(w[7:0]);
          2'b10: if (mdl_cnt != 0) begin mdl_cnt--; nxt = int'(w[4:0]); taken = 1'b1; end
          default: ;
        endcase
      end else begin
        e_exec[te] = 1'b1; e_word[te] = w;
      end
      if (halt || (pc == PROG_DEPTH-1 && !taken)) term_t = te;
      else pc = nxt;
      n++;
    end
    stop_t = (term_t >= 0) ? term_t : abort_at;
    end_t  = stop_t + 1;
    cur = mdl_op;
    for (int t = 0; t < TLEN; t++) begin
      if (e_exec[t]) cur = e_word[t];
      e_op[t] = cur;
      if (t >= stop_t) e_busy[t] = 1'b0;
    end
    if (term_t >= 0) e_done[term_t] = 1'b1;
    mdl_op = cur;
  endtask

  // Copy the model program into the DUT (called at a negedge, DUT idle).
  task automatic load_all();
    for (int i = 0; i < PROG_DEPTH; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = ADDR_W'(i);
      bus.prog_data = mdl_mem[i];
      @(negedge clk);
    end
    bus.prog_we = 1'b0;
  endtask

  // One run: pulse start, compare every cycle, optionally inject ignored
  // start/write traffic while busy, and abort at abort_at if still running.
  task automatic run(input string tag, input int abort_at, input bit noise);
    int term_t, end_t;
    logic [31:0] obs, exp;
    build_trace(abort_at, term_t, end_t);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t <= end_t; t++) begin
      obs = {13'd0, bus.busy, bus.done, bus.execute, bus.opcode};
      exp = {13'd0, e_busy[t], e_done[t], e_exec[t], e_op[t]};
      chk(tag, obs, exp);
      bus.start = 1'b0; bus.prog_we = 1'b0; bus.abort = 1'b0;
      if (term_t < 0 && t == abort_at - 1) bus.abort = 1'b1;
      if (noise && e_busy[t] && (t + 1 < abort_at) && ($urandom_range(0, 2) == 0)) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = ($urandom_range(0, 1) == 0) ? ADDR_W'(0) : ADDR_W'($urandom);
        bus.prog_data = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.abort = 1'b0;
    chk({tag, "_loopcnt"}, 32'(dut.loop_cnt_q), 32'(mdl_cnt));
  endtask

  task automatic clear_prog();
    for (int i = 0; i < PROG_DEPTH; i++) mdl_mem[i] = 16'h0000;
  endtask

  task automatic random_prog();
    logic [15:0] w;
    for (int i = 0; i < PROG_DEPTH; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 19))
        0:          w = 16'hA000;                                     // HALT
        1, 2, 3:    w = {5'b10101, 3'b000, 8'($urandom_range(0, 5))}; // SETLOOP
        4, 5, 6:    w = {5'b10110, 6'd0, 5'($urandom)};               // DJNZ
        7:          w = {5'b10111, 11'($urandom)};                    // reserved
        default:    if (w[15:13] == 3'b101) w[15] = 1'b0;             // core op
      endcase
      mdl_mem[i] = w;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = 16'h0;
    bus.start = 1'b0; bus.abort = 1'b0;
    mdl_cnt = 0; mdl_op = 16'h0000;

    @(negedge clk);
    chk("reset_out", {10'd0, bus.pc, bus.busy, bus.done, bus.execute, bus.opcode},
        32'h0000_0000);
    chk("reset_loopcnt", 32'(dut.loop_cnt_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-word program ending in HALT
    clear_prog();
    mdl_mem[0] = 16'h0105; mdl_mem[1] = 16'h4403; mdl_mem[2] = 16'hA000;
    load_all();
    run("basic", MAXT, 1'b0);

    // Writes and starts while busy must be ignored; replay shows word 0 intact
    run("busy_wr", MAXT, 1'b1);
    run("replay", MAXT, 1'b0);

    // Abort two cycles after the first execute, then rerun from pc 0
    run("abort", 4, 1'b0);
    run("after_abort", MAXT, 1'b0);

    // SETLOOP 3 / DJNZ loop: body executes 4 times, counter ends at 0
    clear_prog();
    mdl_mem[0] = 16'hA803; mdl_mem[1] = 16'h4000;
    mdl_mem[2] = 16'hB001; mdl_mem[3] = 16'hA000;
    load_all();
    run("loop", MAXT, 1'b0);

    // End-of-memory termination: 32 core ops, done with the last execute
    for (int i = 0; i < PROG_DEPTH; i++) mdl_mem[i] = 16'h4001;
    load_all();
    run("eom", MAXT, 1'b0);

    // Asynchronous reset mid-run, then replay of the retained program
    clear_prog();
    mdl_mem[0] = 16'h0105; mdl_mem[1] = 16'h4403; mdl_mem[2] = 16'hA000;
    load_all();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {10'd0, bus.pc, bus.busy, bus.done, bus.execute, bus.opcode},
        32'h0000_0000);
    mdl_cnt = 0; mdl_op = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_rst", MAXT, 1'b0);

    // Randomized programs, random aborts and ignored traffic while busy
    for (int r = 0; r < 25; r++) begin
      random_prog();
      load_all();
      run("rand", ($urandom_range(0, 1) == 0) ? MAXT : int'($urandom_range(1, 60)),
          1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
